temporizador: RTL and testbench

Countdown timer for the microwave controller, sitting directly upstream of `controle_magnetron`. It holds a cooking time of four BCD digits (MM:SS) that is entered from the keypad one digit at a time. While the magnetron is on, it counts that time down once per second. It drives `timer_done` into `controle_magnetron`, consumes `mag_on` from it, and exposes the digits for the display.

---
 rtl/temporizador.sv | 180 ++++++++++++++++++
 tb/tb_temporizador.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/temporizador.sv
// Purpose: four-digit BCD MM:SS countdown timer with keypad entry, feeding controle_magnetron.
// Latency: entry, clear and decrement show up one cycle after the qualifying edge; timer_done is combinational.
// Backpressure: none; keypad strobes are accepted or dropped in the same cycle, mag_on only gates counting.
module temporizador #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       timer_done,
    output logic       tick
);

    // Prescaler width: enough bits to hold TICKS_PER_SEC-1, never below 1.
    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    // Per-cycle operating mode, decoded in priority order (reset is handled in the register block).
    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_CLEAR = 3'd1;
    localparam logic [2:0] MODE_ENTRY = 3'd2;
    localparam logic [2:0] MODE_COUNT = 3'd3;
    localparam logic [2:0] MODE_SAT   = 3'd4;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    // Digit and prescaler registers plus the registered tick.
    logic [3:0]    min_tens_q;
    logic [3:0]    min_units_q;
    logic [3:0]    sec_tens_q;
    logic [3:0]    sec_units_q;
    logic [PW-1:0] presc_q;
    logic          tick_q;

    // Next-state values.
    logic [3:0]    min_tens_d;
    logic [3:0]    min_units_d;
    logic [3:0]    sec_tens_d;
    logic [3:0]    sec_units_d;
    logic [PW-1:0] presc_d;
    logic          tick_d;

    // One-second-less values of the current time.
    logic [3:0]    dec_min_tens;
    logic [3:0]    dec_min_units;
    logic [3:0]    dec_sec_tens;
    logic [3:0]    dec_sec_units;

    logic [2:0]    mode;
    logic          time_zero;
    logic          digit_ok;
    logic          presc_wrap;

    assign time_zero  = (min_tens_q == 4'd0) && (min_units_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_units_q == 4'd0);
    assign digit_ok   = (digit <= BCD_NINE);
    assign presc_wrap = (presc_q == PRESC_MAX);

    // Decode the active mode; keypad inputs only matter while the magnetron is off.
    always_comb begin
        mode = MODE_HOLD;
        if (!mag_on) begin
            if (!clearn) begin
                mode = MODE_CLEAR;
            end else if (digit_valid && digit_ok) begin
                mode = MODE_ENTRY;
            end
        end else begin
            if (!time_zero) begin
                mode = MODE_COUNT;
            end else begin
                mode = MODE_SAT;
            end
        end
    end

    // BCD borrow chain, digit by digit; sec_tens above 5 is left as entered and simply counts down.
    always_comb begin
        dec_min_tens  = min_tens_q;
        dec_min_units = min_units_q;
        dec_sec_tens  = sec_tens_q;
        dec_sec_units = sec_units_q;
        if (sec_units_q != 4'd0) begin
            dec_sec_units = sec_units_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_sec_tens  = sec_tens_q - 4'd1;
            dec_sec_units = BCD_NINE;
        end else if (min_units_q != 4'd0) begin
            dec_min_units = min_units_q - 4'd1;
            dec_sec_tens  = BCD_FIVE;
            dec_sec_units = BCD_NINE;
        end else begin
            // Only reached with min_tens nonzero, since COUNT excludes 00:00.
            dec_min_tens  = min_tens_q - 4'd1;
            dec_min_units = BCD_NINE;
            dec_sec_tens  = BCD_FIVE;
            dec_sec_units = BCD_NINE;
        end
    end

    // Select next digit, prescaler and tick values from the decoded mode.
    always_comb begin
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        presc_d     = presc_q;
        tick_d      = 1'b0;
        case (mode)
            MODE_CLEAR: begin
                min_tens_d  = 4'd0;
                min_units_d = 4'd0;
                sec_tens_d  = 4'd0;
                sec_units_d = 4'd0;
                presc_d     = '0;
            end
            MODE_ENTRY: begin
                // Shift left; the old min_tens falls off the end, prescaler untouched.
                min_tens_d  = min_units_q;
                min_units_d = sec_tens_q;
                sec_tens_d  = sec_units_q;
                sec_units_d = digit;
            end
            MODE_COUNT: begin
                if (presc_wrap) begin
                    presc_d     = '0;
                    min_tens_d  = dec_min_tens;
                    min_units_d = dec_min_units;
                    sec_tens_d  = dec_sec_tens;
                    sec_units_d = dec_sec_units;
                    tick_d      = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            MODE_SAT: begin
                // Expired while running: keep 00:00 and park the prescaler at 0.
                presc_d = '0;
            end
            default: begin
                // HOLD: everything keeps its value (including a paused partial second).
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_tens_q  <= 4'd0;
            min_units_q <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_units_q <= 4'd0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
        end else begin
            min_tens_q  <= min_tens_d;
            min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
        end
    end

    assign min_tens   = min_tens_q;
    assign min_units  = min_units_q;
    assign sec_tens   = sec_tens_q;
    assign sec_units  = sec_units_q;
    assign timer_done = time_zero;
    assign tick       = tick_q;

endmodule

// File: tb/tb_temporizador.sv
// Purpose: directed check of temporizador with TICKS_PER_SEC=4 (vector table plus multi-cycle sequences).
// Latency: every applied cycle is checked 1 time unit after the rising edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_temporizador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clearn = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       mag_on = 1'b0;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       timer_done;
    logic       tick;

    int total = 0;
    int bad   = 0;

    temporizador #(.TICKS_PER_SEC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .clearn      (clearn),
        .digit_valid (digit_valid),
        .digit       (digit),
        .mag_on      (mag_on),
        .min_tens    (min_tens),
        .min_units   (min_units),
        .sec_tens    (sec_tens),
        .sec_units   (sec_units),
        .timer_done  (timer_done),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cn;
        logic        dv;
        logic [3:0]  d;
        logic        mg;
        logic [15:0] t;
        logic        dn;
        logic        tk;
    } vec_t;

    vec_t vt[24];

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic drive(input logic r, input logic cn, input logic dv,
                         input logic [3:0] d, input logic mg);
        reset       = r;
        clearn      = cn;
        digit_valid = dv;
        digit       = d;
        mag_on      = mg;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] et,
                         input logic edn, input logic etk);
        logic [15:0] at;
        at = {min_tens, min_units, sec_tens, sec_units};
        total++;
        if (at !== et || timer_done !== edn || tick !== etk) begin
            bad++;
            $display("FAIL %s: got time=%h done=%b tick=%b, want time=%h done=%b tick=%b",
                     name, at, timer_done, tick, et, edn, etk);
        end
    endtask

    // Expected display for a remaining time; non-normalized keeps everything in seconds.
    function automatic logic [15:0] bcd_of(input int s, input bit norm);
        int m;
        int sc;
        m  = norm ? s / 60 : 0;
        sc = norm ? s % 60 : s;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic enter(input logic [3:0] d);
        drive(1'b0, 1'b1, 1'b1, d, 1'b0);
    endtask

    initial begin
        //          rst  cn   dv   d      mg    time      done tick
        vt[0]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 16'h0013, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 16'h0130, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 4'd5,  1'b0, 16'h0005, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 4'd7,  1'b0, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0004, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 16'h0004, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 16'h0042, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 16'h0042, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b1, 4'd9,  1'b1, 16'h0042, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 16'h0042, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 16'h0041, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 16'h0041, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0};
        vt[17] = '{1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0, 1'b0};
        vt[18] = '{1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 16'h0012, 1'b0, 1'b0};
        vt[19] = '{1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 16'h0123, 1'b0, 1'b0};
        vt[20] = '{1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 16'h1234, 1'b0, 1'b0};
        vt[21] = '{1'b0, 1'b1, 1'b1, 4'd5,  1'b0, 16'h2345, 1'b0, 1'b0};
        vt[22] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 16'h2345, 1'b0, 1'b0};
        vt[23] = '{1'b1, 1'b0, 1'b1, 4'd6,  1'b1, 16'h0000, 1'b1, 1'b0};

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].rst, vt[i].cn, vt[i].dv, vt[i].d, vt[i].mg);
            check($sformatf("vec%0d", i), vt[i].t, vt[i].dn, vt[i].tk);
        end

        // Countdown with borrow from 01:00.
        enter(4'd1); enter(4'd0); enter(4'd0);
        check("load_0100", 16'h0100, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
            check($sformatf("cd_k%0d", k), bcd_of(60 - k / 4, 1'b1), 1'b0, (k % 4) == 0);
        end

        // Completion from 00:02, then saturation with mag_on still high.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        enter(4'd0); enter(4'd2);
        check("load_0002", 16'h0002, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
            if (k <= 8)
                check($sformatf("done_k%0d", k), bcd_of(2 - k / 4, 1'b0),
                      (2 - k / 4) == 0, (k % 4) == 0);
            else
                check($sformatf("sat_k%0d", k), 16'h0000, 1'b1, 1'b0);
        end

        // Pause/resume keeps the partial second; strobes while running are dropped.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        enter(4'd5);
        drive(1'b0, 1'b1, 1'b1, 4'd7, 1'b1);
        check("run1_lockout", 16'h0005, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("run2", 16'h0005, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
            check($sformatf("pause_k%0d", k), 16'h0005, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 4'd8, 1'b1);
        check("resume1", 16'h0005, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("resume2_tick", 16'h0004, 1'b0, 1'b1);

        // Non-normalized 00:90 runs 90 seconds.
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        enter(4'd9); enter(4'd0);
        check("load_0090", 16'h0090, 1'b0, 1'b0);
        for (int k = 1; k <= 360; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
            check($sformatf("n90_k%0d", k), bcd_of(90 - k / 4, 1'b0),
                  (90 - k / 4) == 0, (k % 4) == 0);
        end

        // Reset mid-count overrides everything.
        enter(4'd3);
        check("load_0003", 16'h0003, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("midcount", 16'h0003, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
        check("reset_midcount", 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("after_reset", 16'h0000, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
